// File: rtl/wb_rom_boot_copier_if.sv
// rtl/wb_rom_boot_copier_if.sv - Wishbone classic master bus used by the boot copier
interface wb_rom_boot_copier_if #(
    parameter int WB_ADDRESS_WIDTH = 32,
    parameter int WB_DATA_WIDTH    = 32
) ();
    logic [WB_ADDRESS_WIDTH-1:0]  m_adr;
    logic [WB_DATA_WIDTH-1:0]     m_dat_w;
    logic [WB_DATA_WIDTH-1:0]     m_dat_r;
    logic                         m_cyc;
    logic                         m_stb;
    logic                         m_we;
    logic [WB_DATA_WIDTH/8-1:0]   m_sel;
    logic                         m_ack;
    logic                         m_err;

    modport master (
        output m_adr, m_dat_w, m_cyc, m_stb, m_we, m_sel,
        input  m_dat_r, m_ack, m_err
    );

    modport slave (
        input  m_adr, m_dat_w, m_cyc, m_stb, m_we, m_sel,
        output m_dat_r, m_ack, m_err
    );
endinterface

// File: rtl/wb_rom_boot_copier.sv
// rtl/wb_rom_boot_copier.sv - copies len words from ROM to RAM over Wishbone, then releases the core reset
module wb_rom_boot_copier #(
    parameter int WB_ADDRESS_WIDTH = 32,
    parameter int WB_DATA_WIDTH    = 32,
    parameter int LEN_BITS         = 16,
    parameter int AUTO_START       = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [WB_ADDRESS_WIDTH-1:0] src_base,
    input  logic [WB_ADDRESS_WIDTH-1:0] dst_base,
    input  logic [LEN_BITS-1:0]         len,
    wb_rom_boot_copier_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        cpu_rstn
);
    localparam int BPW = WB_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE, ERR} state_t;

    state_t                      state_q, state_n;
    logic [WB_ADDRESS_WIDTH-1:0] src_q, src_n, dst_q, dst_n, adr_q, adr_n;
    logic [LEN_BITS-1:0]         len_q, len_n, idx_q, idx_n;
    logic [WB_DATA_WIDTH-1:0]    data_q, data_n, dat_w_q, dat_w_n;
    logic                        cyc_q, cyc_n, we_q, we_n;
    logic                        busy_q, busy_n, done_q, done_n, error_q, error_n;
    logic                        cpu_rstn_q, cpu_rstn_n;
    logic                        accept;

    // With AUTO_START the block never rests in IDLE: IDLE is only reachable via reset.
    assign accept = (state_q == IDLE || state_q == DONE || state_q == ERR) &&
                    (start || (state_q == IDLE && AUTO_START != 0));

    always_comb begin
        state_n = state_q;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        idx_n   = idx_q;
        data_n  = data_q;
        adr_n   = adr_q;
        dat_w_n = dat_w_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (accept) begin
                    src_n   = src_base;
                    dst_n   = dst_base;
                    len_n   = len;
                    idx_n   = '0;
                    state_n = (len == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (bus.m_err) begin
                    state_n = ERR;
                end else if (bus.m_ack) begin
                    data_n  = bus.m_dat_r;
                    state_n = RD_GAP;
                end
            end
            RD_GAP: state_n = WR;
            WR: begin
                if (bus.m_err) begin
                    state_n = ERR;
                end else if (bus.m_ack) begin
                    idx_n   = idx_q + 1'b1;
                    state_n = WR_GAP;
                end
            end
            WR_GAP:  state_n = (idx_q < len_q) ? RD : DONE;
            default: state_n = IDLE;
        endcase

        // Address and write data load only on entry to a bus state, so they hold during waits and gaps.
        if (state_n == RD && state_q != RD)
            adr_n = src_n + WB_ADDRESS_WIDTH'(idx_n) * WB_ADDRESS_WIDTH'(BPW);
        if (state_n == WR && state_q != WR) begin
            adr_n   = dst_n + WB_ADDRESS_WIDTH'(idx_n) * WB_ADDRESS_WIDTH'(BPW);
            dat_w_n = data_q;
        end

        cyc_n      = (state_n == RD) || (state_n == WR);
        we_n       = (state_n == WR);
        busy_n     = (state_n == RD) || (state_n == RD_GAP) || (state_n == WR) || (state_n == WR_GAP);
        done_n     = (state_n == DONE);
        error_n    = (state_n == ERR);
        cpu_rstn_n = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            adr_q      <= '0;
            dat_w_q    <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            src_q      <= src_n;
            dst_q      <= dst_n;
            len_q      <= len_n;
            idx_q      <= idx_n;
            data_q     <= data_n;
            adr_q      <= adr_n;
            dat_w_q    <= dat_w_n;
            cyc_q      <= cyc_n;
            we_q       <= we_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            error_q    <= error_n;
            cpu_rstn_q <= cpu_rstn_n;
        end
    end

    // Strobe always accompanies cycle in classic single transfers, so one flop drives both.
    assign bus.m_adr   = adr_q;
    assign bus.m_dat_w = dat_w_q;
    assign bus.m_cyc   = cyc_q;
    assign bus.m_stb   = cyc_q;
    assign bus.m_we    = we_q;
    assign bus.m_sel   = '1;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cpu_rstn    = cpu_rstn_q;
endmodule

// File: tb/tb_wb_rom_boot_copier.sv
// tb/tb_wb_rom_boot_copier.sv - directed bench for wb_rom_boot_copier with a Wishbone ROM/RAM slave model
module tb_wb_rom_boot_copier;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_base = 32'h0;
    logic [31:0] dst_base = 32'h1000;
    logic [15:0] len = 16'd4;
    logic        busy, done, error, cpu_rstn;

    int checks = 0;
    int failures = 0;

    wb_rom_boot_copier_if #(.WB_ADDRESS_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();

    wb_rom_boot_copier #(
        .WB_ADDRESS_WIDTH(32), .WB_DATA_WIDTH(32), .LEN_BITS(16), .AUTO_START(1)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .src_base(src_base), .dst_base(dst_base),
        .len(len), .bus(bus), .busy(busy), .done(done), .error(error), .cpu_rstn(cpu_rstn)
    );

    always #5 clk = ~clk;

    int   rd_wait = 0;
    logic err_en = 1'b0;
    int   err_at = 0;
    int   ws = 0;
    int   wait_cnt = 0;
    int   waits = 0;
    int   unstable = 0;
    int   stb_cnt = 0;
    logic prev_wait = 1'b0;
    logic prev_we = 1'b0;
    logic [31:0] prev_adr = 32'h0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_adr_log[$];
    logic [31:0] wr_dat_log[$];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    always_comb begin
        bus.m_err   = bus.m_cyc && bus.m_stb && bus.m_we && err_en && (ws == err_at);
        bus.m_ack   = bus.m_cyc && bus.m_stb && !bus.m_err && (bus.m_we || wait_cnt >= rd_wait);
        bus.m_dat_r = bus.m_we ? 32'h0 : rom(bus.m_adr);
    end

    always @(posedge clk) begin
        if (bus.m_stb) stb_cnt <= stb_cnt + 1;
        if (bus.m_cyc && bus.m_stb && !bus.m_ack && !bus.m_err) begin
            wait_cnt <= wait_cnt + 1;
            waits    <= waits + 1;
        end else begin
            wait_cnt <= 0;
        end
        if (prev_wait && (bus.m_adr != prev_adr || bus.m_we != prev_we || !bus.m_stb))
            unstable <= unstable + 1;
        prev_wait <= bus.m_cyc && bus.m_stb && !bus.m_ack && !bus.m_err;
        prev_adr  <= bus.m_adr;
        prev_we   <= bus.m_we;
        if (bus.m_cyc && bus.m_stb && bus.m_ack) begin
            if (bus.m_we) begin
                wr_adr_log.push_back(bus.m_adr);
                wr_dat_log.push_back(bus.m_dat_w);
                ws <= ws + 1;
            end else begin
                rd_log.push_back(bus.m_adr);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!done && !error && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_finished"}, 64'(done | error), 64'd1);
    endtask

    initial begin
        int n;
        int rb, wb, sb, wt;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cyc", 64'(bus.m_cyc), 0);
        check_eq("rst_adr", 64'(bus.m_adr), 0);
        check_eq("rst_sel", 64'(bus.m_sel), 64'hF);
        check_eq("rst_flags", {61'd0, busy, done, error}, 0);
        check_eq("rst_cpu_rstn", 64'(cpu_rstn), 0);

        // Auto start after reset release, zero-wait slave
        rstn = 1'b1;
        n = 0;
        while (!bus.m_stb && n < 20) begin @(negedge clk); n++; end
        check_eq("auto_first_stb", 64'(n), 1);
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check_eq("auto_done_latency", 64'(n), 16);
        check_eq("auto_cpu_rstn", 64'(cpu_rstn), 1);
        check_eq("auto_busy", 64'(busy), 0);
        check_eq("auto_wr_count", 64'(wr_adr_log.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("auto_wr_adr%0d", i), 64'(wr_adr_log[i]), 64'(32'h1000 + 4 * i));
            check_eq($sformatf("auto_wr_dat%0d", i), 64'(wr_dat_log[i]), 64'(32'hA0 + i));
        end

        // Source address wrap-around
        rb = rd_log.size(); wb = wr_adr_log.size();
        src_base = 32'hFFFF_FFF8; dst_base = 32'h2000; len = 16'd4;
        pulse_start();
        wait_end("wrap");
        check_eq("wrap_rd0", 64'(rd_log[rb + 0]), 64'hFFFF_FFF8);
        check_eq("wrap_rd1", 64'(rd_log[rb + 1]), 64'hFFFF_FFFC);
        check_eq("wrap_rd2", 64'(rd_log[rb + 2]), 64'h0);
        check_eq("wrap_rd3", 64'(rd_log[rb + 3]), 64'h4);
        check_eq("wrap_wr_dat0", 64'(wr_dat_log[wb + 0]), 64'h4000_009E);
        check_eq("wrap_wr_dat2", 64'(wr_dat_log[wb + 2]), 64'hA0);

        // Three wait states on each read
        wb = wr_adr_log.size(); wt = waits;
        rd_wait = 3; src_base = 32'h10; dst_base = 32'h3000; len = 16'd2;
        pulse_start();
        wait_end("wait");
        rd_wait = 0;
        check_eq("wait_cycles", 64'(waits - wt), 6);
        check_eq("wait_stable", 64'(unstable), 0);
        check_eq("wait_wr0", {wr_adr_log[wb], wr_dat_log[wb]}, {32'h3000, 32'hA4});
        check_eq("wait_wr1", {wr_adr_log[wb + 1], wr_dat_log[wb + 1]}, {32'h3004, 32'hA5});
        check_eq("wait_done", 64'(done), 1);

        // Bus error on the third write
        wb = wr_adr_log.size();
        err_at = ws + 2; err_en = 1'b1;
        src_base = 32'h0; dst_base = 32'h4000; len = 16'd8;
        pulse_start();
        n = 0;
        while (!bus.m_err && n < 200) begin @(negedge clk); n++; end
        check_eq("err_seen", 64'(bus.m_err), 1);
        @(posedge clk); #1;
        err_en = 1'b0;
        check_eq("err_flag", 64'(error), 1);
        check_eq("err_cyc", 64'(bus.m_cyc), 0);
        check_eq("err_cpu_rstn", 64'(cpu_rstn), 0);
        check_eq("err_done_busy", {62'd0, done, busy}, 0);
        check_eq("err_wr_count", 64'(wr_adr_log.size() - wb), 2);

        // Zero-length start from ERR
        @(negedge clk);
        sb = stb_cnt;
        len = 16'd0;
        pulse_start();
        check_eq("len0_done", 64'(done), 1);
        check_eq("len0_error", 64'(error), 0);
        repeat (3) @(negedge clk);
        check_eq("len0_no_stb", 64'(stb_cnt - sb), 0);
        check_eq("len0_cpu_rstn", 64'(cpu_rstn), 1);

        // Normal copy after the error
        wb = wr_adr_log.size();
        src_base = 32'h0; dst_base = 32'h5000; len = 16'd8;
        pulse_start();
        wait_end("retry");
        check_eq("retry_error", 64'(error), 0);
        check_eq("retry_done", 64'(done), 1);
        check_eq("retry_wr_count", 64'(wr_adr_log.size() - wb), 8);
        check_eq("retry_wr7", {wr_adr_log[wb + 7], wr_dat_log[wb + 7]}, {32'h501C, 32'hA7});

        // Reset during the second read, then auto restart with an ignored start
        rb = rd_log.size();
        src_base = 32'h0; dst_base = 32'h6000; len = 16'd4;
        pulse_start();
        n = 0;
        while (!(rd_log.size() == rb + 1 && bus.m_stb && !bus.m_we) && n < 100) begin
            @(negedge clk); n++;
        end
        check_eq("rst_mid_found", 64'(rd_log.size() - rb), 1);
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_mid_cyc_stb", {62'd0, bus.m_cyc, bus.m_stb}, 0);
        check_eq("rst_mid_adr_dat", {bus.m_adr, bus.m_dat_w}, 0);
        check_eq("rst_mid_flags", {60'd0, busy, done, error, cpu_rstn}, 0);
        @(negedge clk);
        rb = rd_log.size(); wb = wr_adr_log.size();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("restart_busy", 64'(busy), 1);
        src_base = 32'h200;
        pulse_start();
        src_base = 32'h0;
        wait_end("restart");
        check_eq("restart_rd_count", 64'(rd_log.size() - rb), 4);
        check_eq("restart_rd0", 64'(rd_log[rb]), 64'h0);
        check_eq("restart_rd3", 64'(rd_log[rb + 3]), 64'hC);
        check_eq("restart_wr3", {wr_adr_log[wb + 3], wr_dat_log[wb + 3]}, {32'h600C, 32'hA3});
        check_eq("restart_done", {62'd0, done, cpu_rstn}, 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
